// File: rtl/scalefac_short_decoder.sv
// scalefac_short_decoder
// Parses the part-2 short-block scalefactors of one granule/channel (pure short
// blocks only) from the bit reader and writes them, band-major/window-minor,
// into the short scalefactor buffer at one 4-bit value per cycle.
module scalefac_short_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] scalefac_compress,
    output logic       busy,
    output logic       done,
    output logic [6:0] bits_consumed,
    output logic       bit_read_enable,
    output logic [2:0] bit_read_count,
    input  logic [3:0] bit_read_data,
    input  logic       bit_read_valid,
    output logic       scalfac_write_enable,
    output logic [1:0] scalfac_write_addr_window,
    output logic [3:0] scalfac_write_addr_index,
    output logic [3:0] scalfac_write_data
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_ZERO  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    logic [2:0] state;
    logic [2:0] slen1;
    logic [1:0] slen2;
    logic [3:0] sfb;
    logic [1:0] win;

    logic [2:0] lut_slen1;
    logic [1:0] lut_slen2;
    logic [2:0] cur_slen;
    logic       accept;
    logic       entry_done;
    logic [3:0] masked_data;

    // slen1/slen2 table indexed by scalefac_compress
    always_comb begin
        lut_slen1 = 3'd0;
        lut_slen2 = 2'd0;
        case (scalefac_compress)
            4'd0:  begin lut_slen1 = 3'd0; lut_slen2 = 2'd0; end
            4'd1:  begin lut_slen1 = 3'd0; lut_slen2 = 2'd1; end
            4'd2:  begin lut_slen1 = 3'd0; lut_slen2 = 2'd2; end
            4'd3:  begin lut_slen1 = 3'd0; lut_slen2 = 2'd3; end
            4'd4:  begin lut_slen1 = 3'd3; lut_slen2 = 2'd0; end
            4'd5:  begin lut_slen1 = 3'd1; lut_slen2 = 2'd1; end
            4'd6:  begin lut_slen1 = 3'd1; lut_slen2 = 2'd2; end
            4'd7:  begin lut_slen1 = 3'd1; lut_slen2 = 2'd3; end
            4'd8:  begin lut_slen1 = 3'd2; lut_slen2 = 2'd1; end
            4'd9:  begin lut_slen1 = 3'd2; lut_slen2 = 2'd2; end
            4'd10: begin lut_slen1 = 3'd2; lut_slen2 = 2'd3; end
            4'd11: begin lut_slen1 = 3'd3; lut_slen2 = 2'd1; end
            4'd12: begin lut_slen1 = 3'd3; lut_slen2 = 2'd2; end
            4'd13: begin lut_slen1 = 3'd3; lut_slen2 = 2'd3; end
            4'd14: begin lut_slen1 = 3'd4; lut_slen2 = 2'd2; end
            4'd15: begin lut_slen1 = 3'd4; lut_slen2 = 2'd3; end
            default: begin lut_slen1 = 3'd0; lut_slen2 = 2'd0; end
        endcase
    end

    // Current entry width, reader request and entry completion; start is refused
    // while busy so the done cycle (already back in IDLE) cannot retrigger
    always_comb begin
        cur_slen        = (sfb < 4'd6) ? slen1 : {1'b0, slen2};
        accept          = (state == ST_IDLE) && start && !busy;
        bit_read_enable = (state == ST_READ) && (cur_slen != 3'd0);
        bit_read_count  = bit_read_enable ? cur_slen : 3'd0;
        entry_done      = (state == ST_READ) && (!bit_read_enable || bit_read_valid);
        case (cur_slen)
            3'd1:    masked_data = {3'b000, bit_read_data[0]};
            3'd2:    masked_data = {2'b00, bit_read_data[1:0]};
            3'd3:    masked_data = {1'b0, bit_read_data[2:0]};
            3'd4:    masked_data = bit_read_data;
            default: masked_data = 4'd0;
        endcase
    end

    // Control FSM walking sfb 0..11 in READ, then the three sfb12 zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            slen1 <= 3'd0;
            slen2 <= 2'd0;
            sfb   <= 4'd0;
            win   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        slen1 <= lut_slen1;
                        slen2 <= lut_slen2;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    sfb   <= 4'd0;
                    win   <= 2'd0;
                    state <= ST_READ;
                end
                ST_READ: begin
                    if (entry_done) begin
                        if (win == 2'd2) begin
                            win <= 2'd0;
                            sfb <= sfb + 4'd1;
                            if (sfb == 4'd11) begin
                                state <= ST_ZERO;
                            end
                        end else begin
                            win <= win + 2'd1;
                        end
                    end
                end
                ST_ZERO: begin
                    if (win == 2'd2) begin
                        win   <= 2'd0;
                        state <= ST_FIN;
                    end else begin
                        win <= win + 2'd1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered buffer write, status flags and part-2 bit count
    always_ff @(posedge clk) begin
        if (rst) begin
            scalfac_write_enable      <= 1'b0;
            scalfac_write_addr_window <= 2'd0;
            scalfac_write_addr_index  <= 4'd0;
            scalfac_write_data        <= 4'd0;
            done                      <= 1'b0;
            busy                      <= 1'b0;
            bits_consumed             <= 7'd0;
        end else begin
            scalfac_write_enable      <= entry_done || (state == ST_ZERO);
            scalfac_write_addr_window <= (entry_done || (state == ST_ZERO)) ? win : 2'd0;
            scalfac_write_addr_index  <= (entry_done || (state == ST_ZERO)) ? sfb : 4'd0;
            scalfac_write_data        <= entry_done ? masked_data : 4'd0;
            done                      <= (state == ST_FIN);
            if (accept) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (accept) begin
                bits_consumed <= 7'd0;
            end else if (entry_done && bit_read_enable) begin
                bits_consumed <= bits_consumed + {4'b0000, cur_slen};
            end
        end
    end

endmodule
